// File: rtl/aes_sub_bytes_seq.sv
// Purpose    : forward AES S-box (SubBytes) over a 128-bit state, LANES bytes per clock.
// Latency    : out_valid rises exactly STEPS = 16/LANES cycles after the accept edge.
// Backpressure: out_state/out_valid hold in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_state byte k = in_state[127-8k -: 8]
//   out_valid/out_ready  output handshake; out_state uses the same byte ordering
//   busy                 high while a block is being processed or awaiting handoff
module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  // A single-step engine still keeps a 1-bit counter so the logic has no zero-width vector.
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Forward S-box, FIPS-197 Fig. 7, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_fsm;
  state_t          w_fsm_nxt;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_data;
  logic [127:0]    w_sub;
  logic            w_last;

  // Substitute the LANES bytes of step c. Every lane reads the unmodified register
  // value, and bytes outside this step pass through untouched.
  function automatic logic [127:0] sub_step(input logic [127:0] d, input logic [CW-1:0] c);
    logic [127:0] res;
    logic [3:0]   k;
    res = d;
    for (int l = 0; l < LANES; l++) begin
      k = 4'(c) * 4'(LANES) + 4'(l);
      // Byte k lives at bits [127-8k -: 8]; for a 4-bit k, 15-k is simply ~k.
      res[{~k, 3'b000} +: 8] = SBOX[d[{~k, 3'b000} +: 8]];
    end
    return res;
  endfunction

  assign w_sub  = sub_step(r_data, r_cnt);
  assign w_last = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm  <= S_IDLE;
      r_cnt  <= '0;
      r_data <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_data <= in_state;
            r_cnt  <= '0;
          end
        end
        S_BUSY: begin
          r_data <= w_sub;
          r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_state = r_data;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Handing off returns to IDLE; a new block waits one more cycle there.
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: one instance per legal LANES value, the
// LANES=4 instance (index 0) carries the main sequence; the others get the sweep.
module tb_aes_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   vld = '0;
  logic [4:0]   rdy;
  logic [4:0]   ovld;
  logic [4:0]   bsy;
  logic [127:0] ost [5];
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] fwd_tab [256];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int LN = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 8 : 16;
    aes_sub_bytes_seq #(.LANES(LN)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[gi]),
      .in_ready  (rdy[gi]),
      .in_state  (in_state),
      .out_valid (ovld[gi]),
      .out_ready (out_ready),
      .out_state (ost[gi]),
      .busy      (bsy[gi])
    );
  end

  // Independent S-box model: GF(2^8) multiplicative inverse followed by the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    if (a != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_model(input logic [7:0] y);
    logic [7:0] r = 8'h00;
    for (int x = 0; x < 256; x++) begin
      if (fwd_tab[x] == y) r = 8'(x);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one block into instance idx, measure latency, check result, hand it off.
  task automatic run_block(input int idx, input logic [127:0] din, input logic [127:0] exp,
                           input int lat_exp, input string tag, output logic [127:0] obs);
    int lat;
    chk({tag, "_in_ready"}, 128'(rdy[idx]), 128'd1);
    in_state = din;
    vld[idx] = 1'b1;
    @(posedge clk); #1;
    vld[idx] = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!ovld[idx] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    obs = ost[idx];
    chk({tag, "_data"}, obs, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, 128'({ovld[idx], rdy[idx]}), 128'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    logic [127:0] obs, din, exp, held, rec;
    int n;
    int lat_tab [5] = '{4, 16, 8, 2, 1};

    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_model(8'(i));

    // Reset state while rst is held.
    #12;
    chk("rst_out_valid", 128'(ovld[0]), 128'd0);
    chk("rst_out_state", ost[0], 128'd0);
    chk("rst_busy", 128'(bsy), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 128'(rdy), 128'h1f);

    // 1) all-zero state
    run_block(0, 128'd0, {16{8'h63}}, 4, "zero", obs);
    // 2) FIPS-197 Appendix B round-1 SubBytes
    run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, 4, "fips", obs);
    // 3) counting bytes, then invert the result through the model
    run_block(0, 128'h000102030405060708090a0b0c0d0e0f,
              128'h637c777bf26b6fc53001672bfed7ab76, 4, "count", obs);
    for (int k = 0; k < 16; k++) rec[8*(15-k) +: 8] = inv_sbox_model(obs[8*(15-k) +: 8]);
    chk("count_inverse", rec, 128'h000102030405060708090a0b0c0d0e0f);

    // 4) backpressure: DONE held for 10 cycles, in_valid pulses must be ignored
    in_state = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    n = 0;
    while (!ovld[0] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_done", 128'(n), 128'd4);
    held = ost[0];
    for (int c = 0; c < 10; c++) begin
      vld[0] = c[0];
      in_state = {4{$urandom}};
      @(posedge clk); #1;
      chk("bp_hold", {ost[0][125:0], ovld[0], rdy[0]}, {held[125:0], 1'b1, 1'b0});
    end
    vld[0] = 1'b0;
    chk("bp_data", ost[0], 128'hd42711aee0bf98f1b8b45de51e415230);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_idle", 128'({rdy[0], ovld[0], bsy[0]}), 128'b100);

    // Throughput with in_valid and out_ready held high: one block per 6 cycles.
    in_state = 128'd0;
    out_ready = 1'b1;
    vld[0] = 1'b1;
    n = 0;
    while (!ovld[0] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tput_first_lat", 128'(n), 128'd5);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ovld[0] && n < 64);
    vld[0] = 1'b0;
    chk("tput_period", 128'(n), 128'd6);
    chk("tput_data", ost[0], {16{8'h63}});
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("tput_idle", 128'({rdy[0], ovld[0]}), 128'b10);

    // 5) reset two cycles into BUSY
    in_state = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_was_busy", 128'(bsy[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {ost[0][124:0], ovld[0], bsy[0], rdy[0]}, 128'b001);
    chk("abort_state", ost[0], 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 128'(rdy[0]), 128'd1);
    run_block(0, {16{8'hff}}, {16{8'h16}}, 4, "after_abort", obs);

    // Whole table through the LANES=4 instance against the algorithmic model.
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) begin
        din[8*(15-k) +: 8] = 8'(16*j + k);
        exp[8*(15-k) +: 8] = fwd_tab[16*j + k];
      end
      run_block(0, din, exp, 4, $sformatf("table_row%0d", j), obs);
    end

    // 6) LANES sweep with the FIPS vector
    for (int i = 1; i < 5; i++) begin
      run_block(i, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd42711aee0bf98f1b8b45de51e415230, lat_tab[i],
                $sformatf("sweep_lanes_idx%0d", i), obs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
